// File: rtl/mem_access_ctrl.sv
// +--------------------------------------------------------------------------+
// | mem_access_ctrl: MEM-stage load/store engine with req/ack data bus.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr_i,
  input  logic        wmem_i,
  input  logic        rmem_i,
  output logic        stall_req,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             memop;
  logic             misaligned;
  logic             at_limit;

  assign memop      = wmem_i | rmem_i;
  assign misaligned = memop & (mem_addr_i[1:0] != 2'b00);
  assign at_limit   = (cnt == CNT_LAST);

  // Released in the ack/abort cycle so EX/MEM advances on the completing edge.
  assign stall_req = (state == IDLE) ? (memop & ~misaligned)
                                     : (~dbus_ack & ~at_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      wb_wd      <= '0;
      wb_wreg    <= 1'b0;
      wb_wdata   <= '0;
      align_err  <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (!memop) begin
            wb_wd    <= mem_wd;
            wb_wreg  <= mem_wreg;
            wb_wdata <= mem_wdata;
          end else if (misaligned) begin
            align_err <= 1'b1;
            wb_wd     <= mem_wd;
            wb_wreg   <= 1'b0;
            wb_wdata  <= mem_wdata;
          end else begin
            dbus_req   <= 1'b1;
            dbus_we    <= wmem_i;
            dbus_addr  <= {mem_addr_i[31:2], 2'b00};
            dbus_wdata <= mem_wdata;
            wb_wreg    <= 1'b0;
            cnt        <= '0;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            state    <= IDLE;
            wb_wd    <= mem_wd;
            // dbus_we is held for the whole access, so it tells load from store.
            if (!dbus_we) begin
              wb_wreg  <= mem_wreg;
              wb_wdata <= dbus_rdata;
            end else begin
              wb_wreg  <= 1'b0;
            end
          end else if (at_limit) begin
            dbus_req <= 1'b0;
            bus_err  <= 1'b1;
            wb_wreg  <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            wb_wreg <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_mem_access_ctrl: randomized instruction stream against an access model|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr_i;
  logic        wmem_i;
  logic        rmem_i;
  logic        stall_req;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        align_err;
  logic        bus_err;

  int n_vec = 0;
  int n_err = 0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_wd     (mem_wd),
    .mem_wreg   (mem_wreg),
    .mem_wdata  (mem_wdata),
    .mem_addr_i (mem_addr_i),
    .wmem_i     (wmem_i),
    .rmem_i     (rmem_i),
    .stall_req  (stall_req),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_wdata (dbus_wdata),
    .dbus_ack   (dbus_ack),
    .dbus_rdata (dbus_rdata),
    .wb_wd      (wb_wd),
    .wb_wreg    (wb_wreg),
    .wb_wdata   (wb_wdata),
    .align_err  (align_err),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One instruction held on the EX/MEM inputs until it retires. ack_at is the
  // WAIT cycle (1-based) carrying the acknowledge; 0 or >TIMEOUT means never.
  task automatic run_instr(input logic w, input logic r, input logic [4:0] wd,
                           input logic wreg, input logic [31:0] data,
                           input logic [31:0] addr, input int ack_at);
    logic        memop;
    logic        mis;
    logic        acked;
    logic        ack_now;
    logic [31:0] rdata;
    memop = w | r;
    mis   = memop && (addr[1:0] != 2'b00);
    mem_wd     = wd;
    mem_wreg   = wreg;
    mem_wdata  = data;
    mem_addr_i = addr;
    wmem_i     = w;
    rmem_i     = r;
    dbus_ack   = 1'($urandom_range(0, 1));
    dbus_rdata = $urandom;
    @(negedge clk);
    check("stall_issue", stall_req, memop && !mis);
    check("req_idle", dbus_req, 1'b0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    if (!memop) begin
      check("pt_wd", wb_wd, wd);
      check("pt_wreg", wb_wreg, wreg);
      check("pt_wdata", wb_wdata, data);
      check("pt_align", align_err, 1'b0);
      check("pt_req", dbus_req, 1'b0);
    end else if (mis) begin
      check("mis_align", align_err, 1'b1);
      check("mis_wreg", wb_wreg, 1'b0);
      check("mis_req", dbus_req, 1'b0);
      check("mis_buserr", bus_err, 1'b0);
    end else begin
      acked = 1'b0;
      rdata = $urandom;
      for (int j = 1; j <= TIMEOUT; j++) begin
        ack_now    = (j == ack_at);
        dbus_ack   = ack_now;
        dbus_rdata = ack_now ? rdata : $urandom;
        @(negedge clk);
        check("stall_wait", stall_req, !ack_now && (j < TIMEOUT));
        check("req_wait", dbus_req, 1'b1);
        check("we_wait", dbus_we, w);
        check("addr_wait", dbus_addr, {addr[31:2], 2'b00});
        check("wdata_wait", dbus_wdata, data);
        check("wreg_wait", wb_wreg, 1'b0);
        check("err_wait", {30'd0, align_err, bus_err}, 32'd0);
        @(posedge clk); #1;
        if (ack_now) begin
          acked = 1'b1;
          break;
        end
      end
      dbus_ack = 1'b0;
      check("req_done", dbus_req, 1'b0);
      check("bus_err", bus_err, !acked);
      check("align_done", align_err, 1'b0);
      if (acked) begin
        check("wb_wd", wb_wd, wd);
        check("wb_wreg", wb_wreg, w ? 1'b0 : wreg);
        if (!w) check("wb_rdata", wb_wdata, rdata);
      end else begin
        check("to_wreg", wb_wreg, 1'b0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          k;
    rst_n = 1'b0;
    mem_wd = '0; mem_wreg = 1'b0; mem_wdata = '0; mem_addr_i = '0;
    wmem_i = 1'b0; rmem_i = 1'b0; dbus_ack = 1'b0; dbus_rdata = '0;
    #1;
    check("rst_req", dbus_req, 1'b0);
    check("rst_wb", {wb_wd, wb_wreg, align_err, bus_err, dbus_we}, 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_wdata", wb_wdata | dbus_wdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the access rules.
    run_instr(1'b0, 1'b0, 5'd5, 1'b1, 32'h1234, 32'h0, 0);
    run_instr(1'b0, 1'b1, 5'd8, 1'b1, 32'h0, 32'h100, 4);
    run_instr(1'b1, 1'b0, 5'd3, 1'b1, 32'hA5A5A5A5, 32'h204, 1);
    run_instr(1'b0, 1'b1, 5'd9, 1'b1, 32'h0, 32'h103, 0);
    run_instr(1'b0, 1'b1, 5'd7, 1'b1, 32'h0, 32'h300, 0);
    run_instr(1'b0, 1'b0, 5'd11, 1'b1, 32'hCAFE0001, 32'h0, 0);
    run_instr(1'b0, 1'b1, 5'd12, 1'b1, 32'h0, 32'h304, TIMEOUT);
    run_instr(1'b1, 1'b1, 5'd13, 1'b1, 32'h5A5A0000, 32'h308, 2);

    // Reset in the middle of a pending load.
    mem_wd = 5'd4; mem_wreg = 1'b1; mem_wdata = 32'h0; mem_addr_i = 32'h400;
    wmem_i = 1'b0; rmem_i = 1'b1; dbus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    wmem_i = 1'b0; rmem_i = 1'b0;
    #1;
    check("midrst_req", dbus_req, 1'b0);
    check("midrst_stall", stall_req, 1'b0);
    check("midrst_wb", {wb_wd, wb_wreg, align_err, bus_err, dbus_we}, 32'd0);
    check("midrst_addr", dbus_addr, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0;
    dbus_ack = 1'b1;
    @(negedge clk);
    check("spur_stall", stall_req, 1'b0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    check("spur_req", dbus_req, 1'b0);
    check("spur_wreg", wb_wreg, 1'b0);
    check("spur_err", {30'd0, align_err, bus_err}, 32'd0);
    run_instr(1'b0, 1'b1, 5'd6, 1'b1, 32'h0, 32'h40, 1);

    // Random instruction stream.
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 3);
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_instr(k[1], k[0] | (k == 1), 5'($urandom), 1'($urandom), $urandom, a,
                $urandom_range(0, TIMEOUT + 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage engine at the consuming end of the EX/MEM pipeline register.
- Takes the registered EX/MEM fields and turns loads and stores into a req/ack transaction on the data bus. Stalls the pipeline until the responder acknowledges.
- Drives the registered MEM/WB fields: load data substituted for loads, pass-through for ALU results, bubble for stores.
- Reports misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: maximum WAIT_ACK cycles before the access is aborted; legal range 2..256.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- mem_wd  input  5  destination register index from EX/MEM
- mem_wreg  input  1  register write enable from EX/MEM
- mem_wdata  input  32  ALU result, or store data when wmem_i=1
- mem_addr_i  input  32  effective byte address
- wmem_i  input  1  store request
- rmem_i  input  1  load request
- stall_req  output  1  combinational; holds IF..EX/MEM while high
- dbus_req  output  1  registered bus request
- dbus_we  output  1  registered; 1=write, 0=read
- dbus_addr  output  32  registered word address, bits[1:0] forced to 0
- dbus_wdata  output  32  registered store data
- dbus_ack  input  1  single-cycle responder acknowledge
- dbus_rdata  input  32  read data, valid in the dbus_ack cycle
- wb_wd  output  5  registered MEM/WB destination register
- wb_wreg  output  1  registered MEM/WB write enable
- wb_wdata  output  32  registered MEM/WB write data
- align_err  output  1  registered one-cycle pulse: misaligned access
- bus_err  output  1  registered one-cycle pulse: timeout abort

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, state=IDLE, counter=0. Reset mid-transaction drops dbus_req immediately; the transaction is lost.
- Op decode: memop = wmem_i | rmem_i. When both are set, the op is a store (wmem_i has priority). misaligned = memop & (mem_addr_i[1:0] != 0).
- FSM states: IDLE, WAIT_ACK.
- IDLE, no memop: at each edge wb_wd<=mem_wd, wb_wreg<=mem_wreg, wb_wdata<=mem_wdata (1-cycle latency). stall_req=0.
- IDLE, misaligned: no bus activity. align_err<=1 for one cycle, wb_wreg<=0, stall_req=0. The instruction retires as a bubble.
- IDLE, aligned memop: stall_req=1 combinationally.
  - At the edge: dbus_req<=1, dbus_we<=wmem_i, dbus_addr<={mem_addr_i[31:2],2'b00}, dbus_wdata<=mem_wdata, wb_wreg<=0, counter<=0, state<=WAIT_ACK.
- WAIT_ACK, dbus_ack=1:
  - stall_req=0 in that same cycle, so EX/MEM advances at that edge.
  - At the edge: dbus_req<=0, state<=IDLE, wb_wd<=mem_wd.
  - Load: wb_wreg<=mem_wreg, wb_wdata<=dbus_rdata.
  - Store: wb_wreg<=0.
- WAIT_ACK, no ack, counter != TIMEOUT-1: stall_req=1, counter increments, bus outputs held stable, wb_wreg<=0 (bubble each stall cycle).
- WAIT_ACK, no ack, counter == TIMEOUT-1: stall_req=0.
  - At the edge: dbus_req<=0, bus_err<=1 for one cycle, wb_wreg<=0, state<=IDLE.
- Ack arriving in the same cycle the counter reaches TIMEOUT-1: the ack wins; no bus_err.
- Minimum access is 2 cycles (issue cycle plus ack cycle). The next instruction is evaluated in IDLE the cycle after completion; back-to-back memops re-issue with no idle gap beyond that.
- dbus_ack while in IDLE (spurious): ignored; no state or output change.
- dbus_addr, dbus_we and dbus_wdata are stable while dbus_req=1.
- align_err and bus_err are never high together.

Test Plan:
- Pass-through: non-memop, mem_wd=5, mem_wreg=1, mem_wdata=0x1234 -> next cycle wb_wd=5, wb_wreg=1, wb_wdata=0x1234; stall_req never high.
- Load, ack after 3 WAIT cycles: rmem_i=1, addr=0x100, wd=8, dbus_rdata=0xDEADBEEF.
  - Expect dbus_req=1, dbus_we=0, dbus_addr=0x100 for 4 cycles.
  - Expect stall_req high for 4 cycles, low in the ack cycle.
  - Expect wb_wreg=1, wb_wd=8, wb_wdata=0xDEADBEEF after the ack edge.
- Store with same-cycle response: wmem_i=1, addr=0x204, data=0xA5A5A5A5, ack in the first WAIT cycle -> dbus_we=1, dbus_wdata=0xA5A5A5A5; wb_wreg=0; total stall 1 cycle.
- Misaligned: rmem_i=1, addr=0x103 -> align_err pulses 1 cycle; dbus_req stays 0; stall_req stays 0; wb_wreg=0.
- Timeout and recovery: TIMEOUT=16, load never acked.
  - Expect bus_err pulse after 16 WAIT cycles; dbus_req drops; stall_req releases.
  - A following ALU op then passes through normally.
  - Variant: ack on the 16th WAIT cycle -> no bus_err, data written back.
- Reset mid-access: rst_n low during WAIT_ACK -> dbus_req=0 and all outputs 0 immediately. After release, state is IDLE and a spurious dbus_ack is ignored.
